// File: rtl/pool2d_pkg.sv
// Shared definitions for the pooling engine: reduction mode, FSM states
// and an address-width helper that is also used by the conv/dense blocks.
package pool2d_pkg;

    typedef enum logic {
        POOL_MAX = 1'b0,
        POOL_AVG = 1'b1
    } pool_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_LAST  = 3'd2,
        ST_WRITE = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

    // Width of an index/address bus covering 'size' entries; never below 1.
    function automatic int addr_width(input int size);
        if (size <= 1) begin
            return 1;
        end else begin
            return $clog2(size);
        end
    endfunction

endpackage

// File: rtl/pool_reduce.sv
// Window accumulator: folds one sample per valid cycle into a running
// MAX or SUM, and presents the pooled value (rounded mean in AVG mode).
module pool_reduce
    import pool2d_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int POOL       = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid,
    input  logic                  first,
    input  pool_mode_e            mode,
    input  logic [DATA_WIDTH-1:0] sample,
    output logic [DATA_WIDTH-1:0] result
);

    // k = log2(POOL^2); the sum of POOL^2 samples needs k extra bits.
    localparam int K  = 2 * $clog2(POOL);
    localparam int AW = DATA_WIDTH + K;

    logic signed [AW-1:0]         acc_r;
    logic signed [AW-1:0]         sample_ext_s;
    logic signed [AW-1:0]         folded_s;
    logic signed [DATA_WIDTH-1:0] avg_s;

    assign sample_ext_s = AW'($signed(sample));

    // Next accumulator value: first sample seeds, later ones fold by mode.
    always_comb begin
        folded_s = acc_r;
        if (first) begin
            folded_s = sample_ext_s;
        end else if (mode == POOL_AVG) begin
            folded_s = acc_r + sample_ext_s;
        end else if (sample_ext_s > acc_r) begin
            folded_s = sample_ext_s;
        end else begin
            folded_s = acc_r;
        end
    end

    // Accumulator register, updated only when a read sample is returning.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= '0;
        end else if (valid) begin
            acc_r <= folded_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    // Mean = (sum + half) >>> k: arithmetic shift rounds half toward +inf.
    generate
        if (K == 0) begin : g_unit
            assign avg_s = acc_r[DATA_WIDTH-1:0];
        end else begin : g_round
            localparam logic signed [AW-1:0] HALF = AW'(1) << (K - 1);
            logic signed [AW-1:0] rounded_s;
            assign rounded_s = (acc_r + HALF) >>> K;
            assign avg_s     = rounded_s[DATA_WIDTH-1:0];
        end
    endgenerate

    // Select the pooled value for the latched mode.
    always_comb begin
        if (mode == POOL_AVG) begin
            result = avg_s;
        end else begin
            result = acc_r[DATA_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/pool2d.sv
// 2-D pooling engine: scans every (channel, oy, ox) output location,
// reads its POOL x POOL window from the conv buffer (1-cycle latency)
// and writes one MAX or rounded-AVG value into the pool buffer.
module pool2d
    import pool2d_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 1,
    parameter int IN_SIZE    = 4,
    parameter int POOL       = 2,
    parameter int STRIDE     = 2,
    parameter int OUT_SIZE   = (IN_SIZE - POOL) / STRIDE + 1
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               start,
    input  logic                                               mode,
    output logic [addr_width(CHANNELS*IN_SIZE*IN_SIZE)-1:0]    conv_addr,
    output logic                                               conv_en,
    input  logic [DATA_WIDTH-1:0]                              conv_q,
    output logic [addr_width(CHANNELS*OUT_SIZE*OUT_SIZE)-1:0]  pool_addr,
    output logic                                               pool_en,
    output logic                                               pool_we,
    output logic [DATA_WIDTH-1:0]                              pool_d,
    output logic                                               busy,
    output logic                                               done
);

    localparam int CAW = addr_width(CHANNELS * IN_SIZE * IN_SIZE);
    localparam int PAW = addr_width(CHANNELS * OUT_SIZE * OUT_SIZE);
    localparam int CHW = addr_width(CHANNELS);
    localparam int OW  = addr_width(OUT_SIZE);
    localparam int WW  = addr_width(POOL);

    state_e                  state_r;
    state_e                  next_s;
    pool_mode_e              mode_r;
    logic [CHW-1:0]          ch_r;
    logic [OW-1:0]           oy_r;
    logic [OW-1:0]           ox_r;
    logic [WW-1:0]           wy_r;
    logic [WW-1:0]           wx_r;
    logic                    sample_valid_r;
    logic                    sample_first_r;
    logic                    win_last_s;
    logic                    out_last_s;
    int                      conv_lin_s;
    int                      pool_lin_s;
    logic [DATA_WIDTH-1:0]   result_s;

    assign win_last_s = (wy_r == WW'(POOL - 1)) && (wx_r == WW'(POOL - 1));
    assign out_last_s = (ch_r == CHW'(CHANNELS - 1)) &&
                        (oy_r == OW'(OUT_SIZE - 1)) &&
                        (ox_r == OW'(OUT_SIZE - 1));

    // State register; reset aborts any pass immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // Next-state logic: READ x POOL^2, LAST, WRITE per output, then FIN.
    always_comb begin
        next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_s = ST_READ;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (win_last_s) begin
                    next_s = ST_LAST;
                end else begin
                    next_s = ST_READ;
                end
            end
            ST_LAST: next_s = ST_WRITE;
            ST_WRITE: begin
                if (out_last_s) begin
                    next_s = ST_FIN;
                end else begin
                    next_s = ST_READ;
                end
            end
            ST_FIN:  next_s = ST_IDLE;
            default: next_s = ST_IDLE;
        endcase
    end

    // Mode is captured only when a start is accepted, so it holds for the pass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_r <= POOL_MAX;
        end else if (state_r == ST_IDLE && start) begin
            mode_r <= pool_mode_e'(mode);
        end else begin
            mode_r <= mode_r;
        end
    end

    // Scan counters: window (wy, wx) steps in READ, location (ch, oy, ox) in WRITE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ch_r <= '0;
            oy_r <= '0;
            ox_r <= '0;
            wy_r <= '0;
            wx_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ch_r <= '0;
                    oy_r <= '0;
                    ox_r <= '0;
                    wy_r <= '0;
                    wx_r <= '0;
                end
                ST_READ: begin
                    if (wx_r == WW'(POOL - 1)) begin
                        wx_r <= '0;
                        if (wy_r == WW'(POOL - 1)) begin
                            wy_r <= '0;
                        end else begin
                            wy_r <= wy_r + WW'(1);
                        end
                    end else begin
                        wx_r <= wx_r + WW'(1);
                    end
                end
                ST_WRITE: begin
                    if (ox_r == OW'(OUT_SIZE - 1)) begin
                        ox_r <= '0;
                        if (oy_r == OW'(OUT_SIZE - 1)) begin
                            oy_r <= '0;
                            if (ch_r == CHW'(CHANNELS - 1)) begin
                                ch_r <= '0;
                            end else begin
                                ch_r <= ch_r + CHW'(1);
                            end
                        end else begin
                            oy_r <= oy_r + OW'(1);
                        end
                    end else begin
                        ox_r <= ox_r + OW'(1);
                    end
                end
                default: begin
                    ch_r <= ch_r;
                    oy_r <= oy_r;
                    ox_r <= ox_r;
                    wy_r <= wy_r;
                    wx_r <= wx_r;
                end
            endcase
        end
    end

    // Track which cycles carry returning read data and which one opens a window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sample_valid_r <= 1'b0;
            sample_first_r <= 1'b0;
        end else begin
            sample_valid_r <= (state_r == ST_READ);
            sample_first_r <= (state_r == ST_READ) &&
                              (wy_r == WW'(0)) && (wx_r == WW'(0));
        end
    end

    pool_reduce #(
        .DATA_WIDTH (DATA_WIDTH),
        .POOL       (POOL)
    ) u_reduce (
        .clk    (clk),
        .rst    (reset),
        .valid  (sample_valid_r),
        .first  (sample_first_r),
        .mode   (mode_r),
        .sample (conv_q),
        .result (result_s)
    );

    // Linear buffer addresses for the current window sample and output location.
    always_comb begin
        conv_lin_s = ((int'(ch_r) * IN_SIZE + int'(oy_r) * STRIDE + int'(wy_r)) * IN_SIZE)
                     + int'(ox_r) * STRIDE + int'(wx_r);
        pool_lin_s = (int'(ch_r) * OUT_SIZE + int'(oy_r)) * OUT_SIZE + int'(ox_r);
    end

    // Output decode from the state; everything is 0 outside its owning state.
    always_comb begin
        conv_en   = 1'b0;
        conv_addr = '0;
        pool_en   = 1'b0;
        pool_we   = 1'b0;
        pool_addr = '0;
        pool_d    = '0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state_r)
            ST_READ: begin
                conv_en   = 1'b1;
                conv_addr = CAW'(conv_lin_s);
                busy      = 1'b1;
            end
            ST_LAST: begin
                busy = 1'b1;
            end
            ST_WRITE: begin
                pool_en   = 1'b1;
                pool_we   = 1'b1;
                pool_addr = PAW'(pool_lin_s);
                pool_d    = result_s;
                busy      = 1'b1;
            end
            ST_FIN: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pool2d.sv
// Bench for pool2d: three instances (4x4 stride-2, 3x3 overlapping
// stride-1, two-channel 4x4) with behavioural conv/pool buffer models.
module tb_pool2d;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    logic clk = 1'b0;
    logic reset;
    logic start [3];
    logic mode [3];
    logic busy [3];
    logic done [3];
    logic conv_en [3];
    logic pool_en [3];
    logic pool_we [3];
    logic [15:0] conv_q [3];
    logic [15:0] pool_d [3];
    logic [3:0] ca0;
    logic [3:0] ca1;
    logic [4:0] ca2;
    logic [1:0] pa0;
    logic [1:0] pa1;
    logic [2:0] pa2;
    int caddr [3];
    int paddr [3];

    logic signed [15:0] cmem [3][64];
    wr_t wr_log [3][$];
    int  rd_log [3][$];
    int  viol = 0;
    int  exp_q[$];
    int  exp_addr[$];
    int  checks;
    int  passed;

    always #5 clk = ~clk;

    assign caddr[0] = int'(ca0);
    assign caddr[1] = int'(ca1);
    assign caddr[2] = int'(ca2);
    assign paddr[0] = int'(pa0);
    assign paddr[1] = int'(pa1);
    assign paddr[2] = int'(pa2);

    pool2d #(.DATA_WIDTH(16), .CHANNELS(1), .IN_SIZE(4), .POOL(2), .STRIDE(2)) dut_a (
        .clk(clk), .reset(reset), .start(start[0]), .mode(mode[0]),
        .conv_addr(ca0), .conv_en(conv_en[0]), .conv_q(conv_q[0]),
        .pool_addr(pa0), .pool_en(pool_en[0]), .pool_we(pool_we[0]),
        .pool_d(pool_d[0]), .busy(busy[0]), .done(done[0]));

    pool2d #(.DATA_WIDTH(16), .CHANNELS(1), .IN_SIZE(3), .POOL(2), .STRIDE(1)) dut_b (
        .clk(clk), .reset(reset), .start(start[1]), .mode(mode[1]),
        .conv_addr(ca1), .conv_en(conv_en[1]), .conv_q(conv_q[1]),
        .pool_addr(pa1), .pool_en(pool_en[1]), .pool_we(pool_we[1]),
        .pool_d(pool_d[1]), .busy(busy[1]), .done(done[1]));

    pool2d #(.DATA_WIDTH(16), .CHANNELS(2), .IN_SIZE(4), .POOL(2), .STRIDE(2)) dut_c (
        .clk(clk), .reset(reset), .start(start[2]), .mode(mode[2]),
        .conv_addr(ca2), .conv_en(conv_en[2]), .conv_q(conv_q[2]),
        .pool_addr(pa2), .pool_en(pool_en[2]), .pool_we(pool_we[2]),
        .pool_d(pool_d[2]), .busy(busy[2]), .done(done[2]));

    // Conv buffer (1-cycle read latency) and pool buffer write logger.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (conv_en[i] === 1'b1) begin
                conv_q[i] <= cmem[i][caddr[i]];
                rd_log[i].push_back(caddr[i]);
            end
            if (pool_en[i] === 1'b1 && pool_we[i] === 1'b1) begin
                wr_log[i].push_back('{addr: paddr[i], data: int'($signed(pool_d[i]))});
            end
        end
    end

    // Output hygiene: strobes consistent, pool_d zero outside writes, done excludes busy.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if ((pool_we[i] !== pool_en[i]) ||
                (pool_we[i] === 1'b1 && conv_en[i] === 1'b1) ||
                (pool_we[i] !== 1'b1 && pool_d[i] !== 16'd0) ||
                (done[i] === 1'b1 && busy[i] === 1'b1)) begin
                viol++;
            end
        end
    end

    function automatic wr_t peek_wr(input int idx, input int pos);
        if (pos < wr_log[idx].size()) return wr_log[idx][pos];
        return '{addr: -1, data: -99999};
    endfunction

    function automatic int peek_rd(input int idx, input int pos);
        if (pos < rd_log[idx].size()) return rd_log[idx][pos];
        return -1;
    endfunction

    // Reference: pool every window of an n x n, c-channel map with stride s.
    task automatic model(input int idx, input int c, input int n, input int p, input int s, input bit avg);
        int o, v, best, sum, num, den, q;
        o = (n - p) / s + 1;
        exp_q.delete();
        for (int ch = 0; ch < c; ch++)
            for (int oy = 0; oy < o; oy++)
                for (int ox = 0; ox < o; ox++) begin
                    sum = 0;
                    best = 0;
                    for (int wy = 0; wy < p; wy++)
                        for (int wx = 0; wx < p; wx++) begin
                            v = int'(cmem[idx][(ch * n + oy * s + wy) * n + ox * s + wx]);
                            if ((wy == 0 && wx == 0) || v > best) best = v;
                            sum += v;
                        end
                    if (avg) begin
                        num = 2 * sum + p * p;
                        den = 2 * p * p;
                        q = num / den;
                        if ((num % den != 0) && (num < 0)) q--;
                        exp_q.push_back(q);
                    end else begin
                        exp_q.push_back(best);
                    end
                end
    endtask

    // Reference conv read address sequence in scan order.
    task automatic model_addr(input int c, input int n, input int p, input int s);
        int o;
        o = (n - p) / s + 1;
        exp_addr.delete();
        for (int ch = 0; ch < c; ch++)
            for (int oy = 0; oy < o; oy++)
                for (int ox = 0; ox < o; ox++)
                    for (int wy = 0; wy < p; wy++)
                        for (int wx = 0; wx < p; wx++)
                            exp_addr.push_back((ch * n + oy * s + wy) * n + ox * s + wx);
    endtask

    task automatic run_pass(input int idx, input bit m, input bit disturb,
                            output int cycles, output int busy_cycles);
        @(negedge clk);
        start[idx] = 1'b1;
        mode[idx]  = m;
        @(negedge clk);
        start[idx] = 1'b0;
        cycles = 1;
        busy_cycles = 0;
        while (done[idx] !== 1'b1 && cycles < 4000) begin
            if (busy[idx] === 1'b1) busy_cycles++;
            if (disturb && cycles == 7) start[idx] = 1'b1;
            else start[idx] = 1'b0;
            if (disturb && cycles >= 7) mode[idx] = ~m;
            @(negedge clk);
            cycles++;
        end
        if (busy[idx] === 1'b1) busy_cycles++;
        start[idx] = 1'b0;
        mode[idx]  = m;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({conv_en[0], pool_en[0], pool_we[0], busy[0], done[0]} !== 5'b0 ||
            ca0 !== 4'd0 || pa0 !== 2'd0 || pool_d[0] !== 16'd0) begin
            $display("FAIL reset_outputs: got en=%b addr=%0d/%0d d=%0d expected all 0",
                     {conv_en[0], pool_en[0], pool_we[0], busy[0], done[0]}, ca0, pa0, pool_d[0]);
        end else passed++;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy[0], busy[1], busy[2], done[0], done[1], done[2]} !== 6'b0)
            $display("FAIL reset_idle: got busy/done %b expected 0",
                     {busy[0], busy[1], busy[2], done[0], done[1], done[2]});
        else passed++;
    endtask

    task automatic test_ramp(input bit avg);
        int cyc, bc, w0;
        int exp_c [4];
        wr_t w;
        if (avg) exp_c = '{3, 5, 11, 13};
        else     exp_c = '{5, 7, 13, 15};
        for (int a = 0; a < 16; a++) cmem[0][a] = 16'(a);
        w0 = wr_log[0].size();
        run_pass(0, avg, 1'b0, cyc, bc);
        checks++;
        if (cyc !== 25) $display("FAIL ramp_done_latency: got %0d expected 25", cyc);
        else passed++;
        checks++;
        if (bc !== 24) $display("FAIL ramp_busy_cycles: got %0d expected 24", bc);
        else passed++;
        checks++;
        if (wr_log[0].size() - w0 !== 4)
            $display("FAIL ramp_write_count: got %0d expected 4", wr_log[0].size() - w0);
        else passed++;
        for (int j = 0; j < 4; j++) begin
            w = peek_wr(0, w0 + j);
            checks++;
            if (w.addr !== j || w.data !== exp_c[j])
                $display("FAIL ramp_%s[%0d]: got addr %0d data %0d expected addr %0d data %0d",
                         avg ? "avg" : "max", j, w.addr, w.data, j, exp_c[j]);
            else passed++;
        end
        @(negedge clk);
        checks++;
        if (done[0] !== 1'b0 || busy[0] !== 1'b0)
            $display("FAIL done_pulse: got done=%b busy=%b expected 0 0", done[0], busy[0]);
        else passed++;
    endtask

    task automatic test_negative();
        int cyc, bc, w0;
        wr_t w;
        for (int a = 0; a < 16; a++) cmem[0][a] = 16'($urandom);
        cmem[0][0] = -16'sd5; cmem[0][1] = -16'sd3; cmem[0][4] = -16'sd8; cmem[0][5] = -16'sd1;
        cmem[0][2] = -16'sd1; cmem[0][3] = -16'sd2; cmem[0][6] = -16'sd2; cmem[0][7] = -16'sd2;
        for (int m = 0; m < 2; m++) begin
            model(0, 1, 4, 2, 2, m[0]);
            w0 = wr_log[0].size();
            run_pass(0, m[0], 1'b0, cyc, bc);
            w = peek_wr(0, w0 + m);
            checks++;
            if (w.data !== (m == 0 ? -1 : -2))
                $display("FAIL neg_window_%0d: got %0d expected %0d", m, w.data, (m == 0 ? -1 : -2));
            else passed++;
            for (int j = 0; j < 4; j++) begin
                w = peek_wr(0, w0 + j);
                checks++;
                if (w.addr !== j || w.data !== exp_q[j])
                    $display("FAIL neg_model mode%0d[%0d]: got %0d expected %0d", m, j, w.data, exp_q[j]);
                else passed++;
            end
        end
    endtask

    task automatic test_overlap();
        int cyc, bc, w0, r0;
        int exp_c [4] = '{4, 5, 7, 8};
        wr_t w;
        for (int a = 0; a < 9; a++) cmem[1][a] = 16'(a);
        model_addr(1, 3, 2, 1);
        w0 = wr_log[1].size();
        r0 = rd_log[1].size();
        run_pass(1, 1'b0, 1'b0, cyc, bc);
        checks++;
        if (cyc !== 25) $display("FAIL overlap_latency: got %0d expected 25", cyc);
        else passed++;
        for (int j = 0; j < 4; j++) begin
            w = peek_wr(1, w0 + j);
            checks++;
            if (w.addr !== j || w.data !== exp_c[j])
                $display("FAIL overlap[%0d]: got addr %0d data %0d expected addr %0d data %0d",
                         j, w.addr, w.data, j, exp_c[j]);
            else passed++;
        end
        checks++;
        if (rd_log[1].size() - r0 !== 16)
            $display("FAIL overlap_read_count: got %0d expected 16", rd_log[1].size() - r0);
        else passed++;
        for (int j = 0; j < 16; j++) begin
            checks++;
            if (peek_rd(1, r0 + j) !== exp_addr[j])
                $display("FAIL overlap_conv_addr[%0d]: got %0d expected %0d", j, peek_rd(1, r0 + j), exp_addr[j]);
            else passed++;
        end
    endtask

    task automatic test_multichannel();
        int cyc, bc, w0, r0;
        int exp_c [8] = '{5, 7, 13, 15, 105, 107, 113, 115};
        wr_t w;
        for (int a = 0; a < 32; a++) cmem[2][a] = 16'((a < 16) ? a : (a - 16 + 100));
        model_addr(2, 4, 2, 2);
        w0 = wr_log[2].size();
        r0 = rd_log[2].size();
        run_pass(2, 1'b0, 1'b1, cyc, bc);
        checks++;
        if (cyc !== 49 || bc !== 48)
            $display("FAIL multich_timing: got done %0d busy %0d expected 49 48", cyc, bc);
        else passed++;
        for (int j = 0; j < 8; j++) begin
            w = peek_wr(2, w0 + j);
            checks++;
            if (w.addr !== j || w.data !== exp_c[j])
                $display("FAIL multich[%0d]: got addr %0d data %0d expected addr %0d data %0d",
                         j, w.addr, w.data, j, exp_c[j]);
            else passed++;
        end
        for (int j = 0; j < 32; j++) begin
            checks++;
            if (peek_rd(2, r0 + j) !== exp_addr[j])
                $display("FAIL multich_conv_addr[%0d]: got %0d expected %0d", j, peek_rd(2, r0 + j), exp_addr[j]);
            else passed++;
        end
        repeat (10) @(negedge clk);
        checks++;
        if (wr_log[2].size() - w0 !== 8 || busy[2] !== 1'b0)
            $display("FAIL multich_no_restart: got writes %0d busy %b expected 8 0",
                     wr_log[2].size() - w0, busy[2]);
        else passed++;
    endtask

    task automatic test_random();
        int cyc, bc, w0, n, s, idx;
        bit m;
        wr_t w;
        for (int r = 0; r < 8; r++) begin
            idx = r % 2;
            n = (idx == 0) ? 4 : 3;
            s = (idx == 0) ? 2 : 1;
            m = 1'($urandom_range(0, 1));
            for (int a = 0; a < n * n; a++) begin
                case ($urandom_range(0, 5))
                    0: cmem[idx][a] = 16'sh7FFF;
                    1: cmem[idx][a] = 16'sh8000;
                    default: cmem[idx][a] = 16'($urandom);
                endcase
            end
            model(idx, 1, n, 2, s, m);
            w0 = wr_log[idx].size();
            run_pass(idx, m, 1'b0, cyc, bc);
            checks++;
            if (cyc !== 25) $display("FAIL random%0d_latency: got %0d expected 25", r, cyc);
            else passed++;
            for (int j = 0; j < 4; j++) begin
                w = peek_wr(idx, w0 + j);
                checks++;
                if (w.addr !== j || w.data !== exp_q[j])
                    $display("FAIL random%0d mode%0d[%0d]: got addr %0d data %0d expected addr %0d data %0d",
                             r, m, j, w.addr, w.data, j, exp_q[j]);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int cyc, bc, w0;
        wr_t w;
        for (int a = 0; a < 16; a++) cmem[0][a] = 16'($urandom);
        for (int m = 1; m >= 0; m--) begin
            model(0, 1, 4, 2, 2, m[0]);
            w0 = wr_log[0].size();
            run_pass(0, m[0], 1'b0, cyc, bc);
            checks++;
            if (cyc !== 25) $display("FAIL b2b_latency mode%0d: got %0d expected 25", m, cyc);
            else passed++;
            for (int j = 0; j < 4; j++) begin
                w = peek_wr(0, w0 + j);
                checks++;
                if (w.addr !== j || w.data !== exp_q[j])
                    $display("FAIL b2b mode%0d[%0d]: got %0d expected %0d", m, j, w.data, exp_q[j]);
                else passed++;
            end
        end
    endtask

    task automatic test_reset_midpass();
        int w0, guard, cyc, bc;
        wr_t w0e, w1e;
        for (int a = 0; a < 16; a++) cmem[0][a] = 16'(a);
        w0 = wr_log[0].size();
        @(negedge clk);
        start[0] = 1'b1;
        mode[0]  = 1'b0;
        @(negedge clk);
        start[0] = 1'b0;
        guard = 0;
        while (wr_log[0].size() - w0 < 2 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        checks++;
        if (conv_en[0] !== 1'b1 || busy[0] !== 1'b1)
            $display("FAIL midpass_reading: got conv_en=%b busy=%b expected 1 1", conv_en[0], busy[0]);
        else passed++;
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({conv_en[0], pool_en[0], pool_we[0], busy[0], done[0]} !== 5'b0 ||
            ca0 !== 4'd0 || pa0 !== 2'd0 || pool_d[0] !== 16'd0)
            $display("FAIL async_reset_outputs: got en=%b addr=%0d/%0d d=%0d expected all 0",
                     {conv_en[0], pool_en[0], pool_we[0], busy[0], done[0]}, ca0, pa0, pool_d[0]);
        else passed++;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        w0e = peek_wr(0, w0);
        w1e = peek_wr(0, w0 + 1);
        checks++;
        if (wr_log[0].size() - w0 !== 2 || w0e.data !== 5 || w1e.data !== 7)
            $display("FAIL reset_keeps_writes: got %0d writes (%0d,%0d) expected 2 (5,7)",
                     wr_log[0].size() - w0, w0e.data, w1e.data);
        else passed++;
        model(0, 1, 4, 2, 2, 1'b0);
        w0 = wr_log[0].size();
        run_pass(0, 1'b0, 1'b0, cyc, bc);
        checks++;
        if (cyc !== 25 || wr_log[0].size() - w0 !== 4)
            $display("FAIL restart_after_reset: got latency %0d writes %0d expected 25 4",
                     cyc, wr_log[0].size() - w0);
        else passed++;
        for (int j = 0; j < 4; j++) begin
            w0e = peek_wr(0, w0 + j);
            checks++;
            if (w0e.addr !== j || w0e.data !== exp_q[j])
                $display("FAIL restart[%0d]: got %0d expected %0d", j, w0e.data, exp_q[j]);
            else passed++;
        end
    endtask

    initial begin
        checks = 0;
        passed = 0;
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            mode[i]  = 1'b0;
        end
        for (int i = 0; i < 3; i++)
            for (int a = 0; a < 64; a++) cmem[i][a] = 16'sd0;
        reset = 1'b1;
        test_reset();
        test_ramp(1'b0);
        test_ramp(1'b1);
        test_negative();
        test_overlap();
        test_multichannel();
        test_random();
        test_back_to_back();
        test_reset_midpass();
        checks++;
        if (viol !== 0) $display("FAIL output_hygiene: got %0d violations expected 0", viol);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/pool2d.md
Name: pool2d

Overview:
- Parametrised 2-D pooling engine; successor to the fixed 2x2 max-pool stage between the conv feature-map buffer and the pool buffer.
- Adds configurable window and stride, including overlapping windows.
- Adds a run-time MAX/AVG mode with rounded averaging and a busy indication.
- Reads the conv buffer, which has 1-cycle read latency, and writes one pooled value per output location into the pool buffer.

Parameters:
- DATA_WIDTH, 16, signed sample width.
- CHANNELS, 1, number of feature-map channels.
- IN_SIZE, 4, input height/width (square).
- POOL, 2, window height/width; must be a power of two, >=1.
- STRIDE, 2, window step; 1 <= STRIDE <= POOL.
- OUT_SIZE, (IN_SIZE-POOL)/STRIDE+1, derived; do not override.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a pass when idle.
- mode  in  1  0=MAX, 1=AVG; sampled on the accepted start.
- conv_addr  out  $clog2(CHANNELS*IN_SIZE^2)  conv buffer read address.
- conv_en  out  1  conv read enable.
- conv_q  in  DATA_WIDTH  read data; valid the cycle after conv_en.
- pool_addr  out  $clog2(CHANNELS*OUT_SIZE^2)  pool buffer address.
- pool_en  out  1  pool buffer enable.
- pool_we  out  1  pool buffer write enable.
- pool_d  out  DATA_WIDTH  pooled result.
- busy  out  1  high from the accepted start until done.
- done  out  1  one-cycle pulse after the last write.

Behaviour:
- Reset: asynchronous, active-high. All outputs 0, FSM to IDLE, counters cleared. Reset mid-pass aborts immediately; pool entries already written stay written.
- Start acceptance: start is accepted only in IDLE. start while busy is ignored; the mode latched at acceptance holds for the whole pass.
- Address maps:
  - conv_addr = (ch*IN_SIZE + oy*STRIDE+wy)*IN_SIZE + ox*STRIDE+wx.
  - pool_addr = (ch*OUT_SIZE+oy)*OUT_SIZE+ox.
- Scan order: ch outer, then oy, ox; window wy, wx row-major inside.
- FSM states:
  - IDLE: on start, go to READ.
  - READ: POOL^2 cycles, conv_en=1, one window address per cycle. On the last window address go to LAST.
  - LAST: conv_en=0; absorbs the final returning sample. Go to WRITE.
  - WRITE: pool_en=pool_we=1 for one cycle with pool_addr/pool_d. Then advance (ox, oy, ch) and go to READ, or go to FIN if this was the final output.
  - FIN: done=1 for one cycle, busy=0. Go to IDLE.
- Accumulation: each cycle after a conv_en cycle, conv_q is folded into the accumulator. The first sample of a window initialises it; there is no sentinel value.
- MAX: signed comparison; on ties keep either (value identical).
- AVG: sum held in DATA_WIDTH+2*log2(POOL) bits, so no overflow. Result = (sum + 2^(k-1)) >>> k, with k = 2*log2(POOL), arithmetic shift (round half toward +inf). For POOL=1 the result is the sample.
- Timing: POOL^2+2 cycles per output. done asserts CHANNELS*OUT_SIZE^2*(POOL^2+2)+1 cycles after the accepted start edge. busy covers exactly that interval minus the done cycle.
- Outputs outside the states above are 0: conv_en, pool_en, pool_we, done, and pool_d (outside WRITE).

Decomposition:
- Shared package holds pool_mode_e (POOL_MAX, POOL_AVG), the state enum, and a clog2-safe address-width function. The width function returns 1 for a size of 1, and is shared with conv/dense blocks.
- One sub-module, pool_reduce: window accumulator with first/valid/mode inputs, MAX/AVG fold and rounding, parametrised on DATA_WIDTH and POOL.

Test Plan:
- Ramp 0..15 in a 4x4, POOL=2, STRIDE=2, MAX -> pool = [5,7,13,15]; done at start+25 cycles.
- Same ramp, AVG -> [3,5,11,13], since 2.5, 4.5, 10.5 and 12.5 each round up.
- 2x2 window {-5,-3,-8,-1}: MAX -> -1. Window {-1,-2,-2,-2}: AVG -> -2.
- Overlapping windows: IN_SIZE=3, POOL=2, STRIDE=1, ramp 0..8, MAX -> [4,5,7,8]. Also check every conv_addr sequence against the address formula.
- CHANNELS=2, ch1 = ch0+100, MAX -> [5,7,13,15,105,107,113,115]. A start pulse issued mid-pass is ignored, and mode toggled mid-pass has no effect.
- Reset asserted during the third output -> all outputs 0 asynchronously, with no further writes. pool[0..1] keep their values. A fresh start completes correctly.
